// File: rtl/final_project.sv
// final_project: TMR 8-tap MAC demonstrator with copy-0 fault injection,
// sticky disagreement flags and a three-page LED display.
module final_project (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  input  logic       Err_mult,
  input  logic       Err_mac,
  input  logic [1:0] c_select,
  input  logic       next,
  output logic [7:0] led
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0][15:0] acc_q, acc_d;
  logic [15:0]      result_q, result_d;
  logic [1:0]       c_lat_q, c_lat_d;
  logic             mult_err_q, mult_err_d;
  logic             mac_err_q, mac_err_d;
  logic             done_q, done_d;
  logic [1:0]       page_q, page_d;
  logic             x_dly_q, next_dly_q;

  logic             x_edge, next_edge, busy;
  logic [7:0]       w, xv;
  logic [2:0][15:0] prod, nxt;
  logic [15:0]      p_v, acc_v;

  function automatic logic [7:0] w_rom(input logic [1:0] c, input logic [2:0] i);
    return c == 2'd0 ? 8'd1 :
           c == 2'd1 ? {5'd0, i} + 8'd1 :
           c == 2'd2 ? 8'd8 - {5'd0, i} :
           (i[0] ? 8'd0 : 8'd2);
  endfunction

  function automatic logic [15:0] vote(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign x_edge    = x & ~x_dly_q;
  assign next_edge = next & ~next_dly_q;
  assign busy      = state_q != IDLE;

  // Every copy reloads from the voted value, so a single-copy fault never persists
  always_comb begin
    w     = w_rom(c_lat_q, idx_q);
    xv    = {5'd0, idx_q} + 8'd1;
    for (int k = 0; k < 3; k++)
      prod[k] = ({8'd0, w} * {8'd0, xv}) ^ {15'd0, (k == 0) && Err_mult};
    p_v   = vote(prod[0], prod[1], prod[2]);
    acc_v = vote(acc_q[0], acc_q[1], acc_q[2]);
    for (int k = 0; k < 3; k++)
      nxt[k] = (acc_v + p_v) ^ {7'd0, (k == 0) && Err_mac, 8'd0};
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    result_d   = result_q;
    c_lat_d    = c_lat_q;
    mult_err_d = mult_err_q;
    mac_err_d  = mac_err_q;
    done_d     = done_q;
    page_d     = next_edge ? (page_q == 2'd2 ? 2'd0 : page_q + 2'd1) : page_q;
    case (state_q)
      IDLE: if (x_edge) begin
        state_d    = RUN;
        c_lat_d    = c_select;
        idx_d      = 3'd0;
        acc_d      = '0;
        mult_err_d = 1'b0;
        mac_err_d  = 1'b0;
        done_d     = 1'b0;
      end
      RUN: begin
        acc_d      = nxt;
        mult_err_d = mult_err_q | (prod[0] != prod[1]) | (prod[1] != prod[2]);
        mac_err_d  = mac_err_q | (nxt[0] != nxt[1]) | (nxt[1] != nxt[2]);
        idx_d      = idx_q + 3'd1;
        state_d    = idx_q == 3'd7 ? DONE : RUN;
      end
      DONE: begin
        result_d = acc_v;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      acc_q      <= '0;
      result_q   <= 16'd0;
      c_lat_q    <= 2'd0;
      mult_err_q <= 1'b0;
      mac_err_q  <= 1'b0;
      done_q     <= 1'b0;
      page_q     <= 2'd0;
      x_dly_q    <= 1'b0;
      next_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      c_lat_q    <= c_lat_d;
      mult_err_q <= mult_err_d;
      mac_err_q  <= mac_err_d;
      done_q     <= done_d;
      page_q     <= page_d;
      x_dly_q    <= x;
      next_dly_q <= next;
    end

  assign led = page_q == 2'd1 ? result_q[15:8] :
               page_q == 2'd2 ? {busy, done_q, mult_err_q, mac_err_q, c_lat_q, 2'b00} :
               result_q[7:0];
endmodule

// File: tb/tb_final_project.sv
// tb_final_project: directed checks of the TMR MAC demonstrator; inputs change
// and outputs are sampled on the falling edge.
module tb_final_project;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x = 1'b0;
  logic       Err_mult = 1'b0;
  logic       Err_mac = 1'b0;
  logic [1:0] c_select = 2'd0;
  logic       next = 1'b0;
  logic [7:0] led;
  int         errors = 0;
  int         checks = 0;

  final_project dut (
    .clk(clk), .rst(rst), .x(x), .Err_mult(Err_mult), .Err_mac(Err_mac),
    .c_select(c_select), .next(next), .led(led)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (led === exp) else begin
      errors++;
      $error("FAIL %s led=%h expected=%h", tag, led, exp);
    end
  endtask

  task automatic pulse_next();
    next = 1'b1;
    step(1);
    next = 1'b0;
    step(1);
  endtask

  // one-cycle x pulse sampled at E0, then wait until just after E9
  task automatic run(input logic [1:0] c);
    c_select = c;
    x = 1'b1;
    step(1);
    x = 1'b0;
    step(9);
  endtask

  initial begin
    step(2);
    check("reset", 8'h00);
    rst = 1'b1;
    step(1);

    run(2'd0);
    check("c0_page0", 8'h24);
    pulse_next();
    check("c0_page1", 8'h00);
    pulse_next();
    check("c0_page2", 8'h40);
    pulse_next();
    check("c0_wrap_page0", 8'h24);

    run(2'd1);
    check("c1_page0", 8'hCC);
    pulse_next();
    check("c1_page1", 8'h00);
    pulse_next();
    check("c1_page2", 8'h44);
    pulse_next();

    Err_mult = 1'b1;
    run(2'd2);
    Err_mult = 1'b0;
    check("c2_mult_fault_page0", 8'h78);
    pulse_next();
    pulse_next();
    check("c2_mult_flag_page2", 8'h68);
    pulse_next();

    c_select = 2'd3;
    x = 1'b1;
    step(1);
    x = 1'b0;
    Err_mac = 1'b1;
    step(2);
    Err_mac = 1'b0;
    step(7);
    check("c3_mac_fault_page0", 8'h20);
    pulse_next();
    pulse_next();
    check("c3_mac_flag_page2", 8'h5C);

    c_select = 2'd0;
    x = 1'b1;
    step(1);
    x = 1'b0;
    step(1);
    check("busy_flags_cleared", 8'h80);
    step(8);
    check("clean_done_page2", 8'h40);

    c_select = 2'd1;
    x = 1'b1;
    step(1);
    x = 1'b0;
    c_select = 2'd2;
    step(3);
    x = 1'b1;
    step(1);
    x = 1'b0;
    step(4);
    check("busy_at_E8", 8'h84);
    step(1);
    check("no_restart_E9", 8'h44);
    step(3);
    check("still_idle", 8'h44);
    pulse_next();
    check("no_restart_result", 8'hCC);

    pulse_next();
    pulse_next();
    check("pre_abort_page2", 8'h44);
    c_select = 2'd2;
    x = 1'b1;
    step(1);
    x = 1'b0;
    step(4);
    check("mid_run_page2", 8'h88);
    rst = 1'b0;
    #1;
    check("async_reset", 8'h00);
    step(1);
    rst = 1'b1;
    step(1);
    pulse_next();
    check("reset_page1", 8'h00);
    pulse_next();
    check("reset_page2", 8'h00);
    pulse_next();

    c_select = 2'd2;
    x = 1'b1;
    next = 1'b1;
    step(1);
    x = 1'b0;
    next = 1'b0;
    step(9);
    check("joint_edge_page1", 8'h00);
    pulse_next();
    check("joint_edge_page2", 8'h48);
    pulse_next();
    check("restart_after_abort", 8'h78);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
